// File: rtl/grid_sprite_renderer.sv
// grid_sprite_renderer: raster-walking tile renderer for the object grid.
// Maps each pixel to a grid cell, fetches the cell's sprite texel from an
// external ROM, and emits colour with syncs delayed by LAT = 3 + ROM_LATENCY.
// The grid is snapshotted once per frame; key colour and blinking codes
// fall back to the background colour.
module grid_sprite_renderer #(
    parameter int GRID_ROWS   = 8,
    parameter int GRID_COLS   = 13,
    parameter int TILE_LOG2   = 5,
    parameter int OBJ_BITS    = 4,
    parameter int X0          = 112,
    parameter int Y0          = 0,
    parameter int ROM_LATENCY = 2,
    parameter int ROM_AW      = 14,
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter logic [11:0] BG_COLOR  = 12'hFFF,
    parameter logic [(1<<OBJ_BITS)-1:0] BLINK_MASK = 16'h0300,
    parameter int BLINK_LOG2  = 4
) (
    input  logic                                    pixel_clk_in,
    input  logic                                    rst_in,
    input  logic [GRID_ROWS*GRID_COLS*OBJ_BITS-1:0] object_grid,
    input  logic [10:0]                             hcount,
    input  logic [9:0]                              vcount,
    input  logic                                    hsync_in,
    input  logic                                    vsync_in,
    input  logic                                    blank_in,
    output logic [ROM_AW-1:0]                       rom_addr,
    input  logic [11:0]                             rom_data,
    output logic [11:0]                             pixel_out,
    output logic                                    hsync_out,
    output logic                                    vsync_out,
    output logic                                    blank_out
);

    localparam int TILE   = 1 << TILE_LOG2;
    localparam int LAT    = 3 + ROM_LATENCY;
    localparam int STAGES = LAT - 1;
    localparam int CW     = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int RW     = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int GW     = GRID_ROWS * GRID_COLS * OBJ_BITS;
    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0 + GRID_COLS * TILE);
    localparam logic [11:0] Y_LO = 12'(Y0);
    localparam logic [11:0] Y_HI = 12'(Y0 + GRID_ROWS * TILE);

    typedef struct packed { logic hs; logic vs; logic bl; } ctl_t;
    typedef struct packed { logic nz; logic sup; } meta_t;

    // 12-bit offsets; range test is done on the unsubtracted values so
    // pixels left of / above the grid never wrap into it.
    logic [11:0] hx, vy, dx, dy;
    logic        hit, frame_start;
    ctl_t        ctl_in;
    assign hx          = {1'b0, hcount};
    assign vy          = {2'b0, vcount};
    assign dx          = hx - X_LO;
    assign dy          = vy - Y_LO;
    assign hit         = (hx >= X_LO) && (hx < X_HI) && (vy >= Y_LO) && (vy < Y_HI);
    assign frame_start = (hcount == '0) && (vcount == '0);
    assign ctl_in      = {hsync_in, vsync_in, blank_in};

    logic [GW-1:0]         snapshot;
    logic [BLINK_LOG2:0]   frame_cnt;
    logic [OBJ_BITS-1:0]   snap_cell [GRID_ROWS][GRID_COLS];

    for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
        for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
            assign snap_cell[r][c] = snapshot[(r*GRID_COLS+c)*OBJ_BITS +: OBJ_BITS];
        end
    end

    // Capture the grid and advance the frame counter at frame start only.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            snapshot  <= '0;
            frame_cnt <= '0;
        end else if (frame_start) begin
            snapshot  <= object_grid;
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    logic [STAGES:0]      vld_pipe;
    ctl_t [STAGES:0]      ctl_pipe;
    logic                 s0_in;
    logic [CW-1:0]        s0_col;
    logic [RW-1:0]        s0_row;
    logic [TILE_LOG2-1:0] s0_px, s0_py;

    // S0: tile coordinates, plus valid/control shift registers for all stages.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            vld_pipe <= '0;
            ctl_pipe <= '0;
            s0_in    <= 1'b0;
            s0_col   <= '0;
            s0_row   <= '0;
            s0_px    <= '0;
            s0_py    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            ctl_pipe <= {ctl_pipe[STAGES-1:0], ctl_in};
            s0_in    <= hit;
            s0_col   <= hit ? CW'(dx >> TILE_LOG2) : '0;
            s0_row   <= hit ? RW'(dy >> TILE_LOG2) : '0;
            s0_px    <= dx[TILE_LOG2-1:0];
            s0_py    <= dy[TILE_LOG2-1:0];
        end
    end

    logic [OBJ_BITS-1:0]  code_lk, s1_code;
    logic                 s1_sup;
    logic [TILE_LOG2-1:0] s1_px, s1_py;
    assign code_lk = snap_cell[s0_row][s0_col];

    // S1: cell lookup and blink decision, using the frame count of this frame.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            s1_code <= '0;
            s1_sup  <= 1'b0;
            s1_px   <= '0;
            s1_py   <= '0;
        end else begin
            s1_code <= s0_in ? code_lk : '0;
            s1_sup  <= s0_in && BLINK_MASK[code_lk] && frame_cnt[BLINK_LOG2];
            s1_px   <= s0_px;
            s1_py   <= s0_py;
        end
    end

    meta_t                 meta_s1;
    meta_t [ROM_LATENCY:0] m_pipe;
    assign meta_s1 = {(s1_code != '0), s1_sup};

    // S2: ROM address, with per-pixel decisions delayed to meet rom_data.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            rom_addr <= '0;
            m_pipe   <= '0;
        end else begin
            rom_addr <= ROM_AW'({s1_code, s1_py, s1_px});
            m_pipe   <= {m_pipe[ROM_LATENCY-1:0], meta_s1};
        end
    end

    ctl_t  co;
    meta_t mo;
    assign co = ctl_pipe[STAGES];
    assign mo = m_pipe[ROM_LATENCY];

    // Output stage: blanking, background, transparency and texel select.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            pixel_out <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b0;
        end else begin
            hsync_out <= co.hs;
            vsync_out <= co.vs;
            blank_out <= co.bl;
            if (!vld_pipe[STAGES] || co.bl)
                pixel_out <= '0;
            else if (!mo.nz || mo.sup || rom_data == KEY_COLOR)
                pixel_out <= BG_COLOR;
            else
                pixel_out <= rom_data;
        end
    end

endmodule

// File: tb/tb_grid_sprite_renderer.sv
// Bench for grid_sprite_renderer: two builds (ROM latency 2 and 1) share one
// directed raster stimulus and are checked every cycle against a pixel-level
// model, plus hand-computed literal pixels at chosen coordinates.
module tb_grid_sprite_renderer;

    localparam logic [11:0] BG  = 12'hFFF;
    localparam logic [11:0] KEY = 12'hF0F;
    localparam logic [15:0] MASK = 16'h0300;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [415:0] grid;
    logic [3:0]   g [8][13];
    logic [10:0]  hc = '0;
    logic [9:0]   vc = '0;
    logic         hs = 1'b0, vs = 1'b0, bl = 1'b0;

    logic [13:0] addr5, addr4;
    logic [11:0] rd5, rd4, pix5, pix4, r5a, r5b, r4a;
    logic        hs5, vs5, bl5, hs4, vs4, bl4;

    for (genvar r = 0; r < 8; r++) begin : g_r
        for (genvar c = 0; c < 13; c++) begin : g_c
            assign grid[(r*13+c)*4 +: 4] = g[r][c];
        end
    end

    grid_sprite_renderer u5 (
        .pixel_clk_in(clk), .rst_in(rst_n), .object_grid(grid),
        .hcount(hc), .vcount(vc), .hsync_in(hs), .vsync_in(vs), .blank_in(bl),
        .rom_addr(addr5), .rom_data(rd5), .pixel_out(pix5),
        .hsync_out(hs5), .vsync_out(vs5), .blank_out(bl5));

    grid_sprite_renderer #(.ROM_LATENCY(1)) u4 (
        .pixel_clk_in(clk), .rst_in(rst_n), .object_grid(grid),
        .hcount(hc), .vcount(vc), .hsync_in(hs), .vsync_in(vs), .blank_in(bl),
        .rom_addr(addr4), .rom_data(rd4), .pixel_out(pix4),
        .hsync_out(hs4), .vsync_out(vs4), .blank_out(bl4));

    // Sprite ROM contents: code 1 green with one key texel at (5,7).
    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        logic [3:0] code;
        logic [4:0] py, px;
        code = a[13:10]; py = a[9:5]; px = a[4:0];
        case (code)
            4'd1:    rom_fn = (px == 5'd5 && py == 5'd7) ? 12'hF0F : 12'h0F0;
            4'd2:    rom_fn = 12'h888;
            4'd3:    rom_fn = 12'h00F;
            4'd8:    rom_fn = 12'h880;
            default: rom_fn = {a[3:0], a[7:4], a[11:8]} ^ 12'h111;
        endcase
    endfunction

    // ROM models with 2- and 1-clock read latency.
    always @(posedge clk) begin
        r5a <= rom_fn(addr5);
        r5b <= r5a;
        r4a <= rom_fn(addr4);
    end
    assign rd5 = r5b;
    assign rd4 = r4a;

    // Model state and per-edge expectations.
    int          cyc = 0, errors = 0, checks = 0, nstep = 0, m_fcnt = 0;
    logic [3:0]  m_snap [8][13];
    logic [11:0] exp_pix [DEPTH];
    logic        exp_hs [DEPTH], exp_vs [DEPTH], exp_bl [DEPTH];
    bit          rst_at [DEPTH];
    bit          lit_on [DEPTH];
    logic [11:0] lit_pix [DEPTH];

    function automatic logic [11:0] model_pix(input int h, input int v, input logic b);
        int col, row, px, py;
        logic [3:0]  code;
        logic [11:0] tex;
        if (b) return 12'h000;
        if (h < 112 || h >= 112 + 13*32 || v >= 8*32) return BG;
        col = (h - 112) / 32; row = v / 32;
        px = (h - 112) % 32;  py = v % 32;
        code = m_snap[row][col];
        if (code == 4'd0) return BG;
        if (MASK[code] && ((m_fcnt / 16) % 2 == 1)) return BG;
        tex = rom_fn({code, 5'(py), 5'(px)});
        return (tex == KEY) ? BG : tex;
    endfunction

    task automatic model_step();
        int t;
        t = cyc;
        rst_at[t] = !rst_n;
        if (!rst_n) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 13; c++) m_snap[r][c] = 4'd0;
            m_fcnt = 0;
            exp_pix[t] = 12'h000;
        end else begin
            if (hc == 11'd0 && vc == 10'd0) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 13; c++) m_snap[r][c] = g[r][c];
                m_fcnt = (m_fcnt + 1) % 32;
            end
            exp_pix[t] = model_pix(int'(hc), int'(vc), bl);
        end
        exp_hs[t] = hs; exp_vs[t] = vs; exp_bl[t] = bl;
        cyc = cyc + 1;
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input int L, input logic [11:0] p, input logic h, input logic v, input logic b);
        int last, s;
        bit dirty;
        logic [11:0] ep;
        logic eh, ev, eb;
        last = cyc - 1;
        s = last - L;
        if (s < 0) return;
        dirty = 0;
        for (int k = s; k <= last; k++) if (rst_at[k]) dirty = 1;
        ep = dirty ? 12'h000 : exp_pix[s];
        eh = dirty ? 1'b0 : exp_hs[s];
        ev = dirty ? 1'b0 : exp_vs[s];
        eb = dirty ? 1'b0 : exp_bl[s];
        checks++;
        if (p !== ep || h !== eh || v !== ev || b !== eb) begin
            errors++;
            $display("FAIL out_lat%0d edge %0d: got pix=%h hs=%b vs=%b blank=%b, want pix=%h hs=%b vs=%b blank=%b",
                     L, last, p, h, v, b, ep, eh, ev, eb);
        end
        if (!dirty && lit_on[s]) begin
            checks++;
            if (p !== lit_pix[s]) begin
                errors++;
                $display("FAIL literal_lat%0d sample %0d: got pix=%h, want %h", L, s, p, lit_pix[s]);
            end
        end
    endtask

    // Compare process: outputs sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            chk(5, pix5, hs5, vs5, bl5);
            chk(4, pix4, hs4, vs4, bl4);
        end
    end

    task automatic step(input int h, input int v, input logic b, input bit ul, input logic [11:0] lv);
        @(negedge clk);
        hc = 11'(h); vc = 10'(v); bl = b;
        hs = nstep[2]; vs = nstep[5];
        nstep++;
        lit_on[cyc] = ul;
        lit_pix[cyc] = lv;
    endtask

    task automatic drv(input int h, input int v, input logic [11:0] lv);
        step(h, v, 1'b0, 1'b1, lv);
    endtask

    task automatic drvn(input int h, input int v);
        step(h, v, 1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 13; c++) g[r][c] = 4'd0;
        rst_n = 1'b0;
        repeat (3) drvn(5, 5);
        rst_n = 1'b1;
        g[0][0] = 4'd1; g[2][4] = 4'd8; g[7][12] = 4'd2;

        // frame 1: tile (0,0) edges along line 0
        drv(0, 0, BG);
        for (int h = 100; h <= 150; h++)
            drv(h, 0, (h >= 112 && h <= 143) ? 12'h0F0 : BG);
        // key texel at offset (5,7) and its neighbours
        drv(116, 7, 12'h0F0); drv(117, 7, BG); drv(118, 7, 12'h0F0);
        drv(117, 6, 12'h0F0); drv(117, 8, 12'h0F0);
        // tile / grid boundaries
        drv(112, 31, 12'h0F0); drv(112, 32, BG); drv(143, 31, 12'h0F0); drv(144, 31, BG);
        drv(250, 70, 12'h880);
        drv(527, 255, 12'h888); drv(528, 255, BG); drv(527, 256, BG); drv(111, 0, BG);
        step(120, 10, 1'b1, 1'b1, 12'h000);

        // mid-frame grid change has no effect until next frame start
        drv(120, 100, BG);
        g[0][0] = 4'd3;
        drv(120, 100, BG); drv(120, 10, 12'h0F0);
        drv(0, 0, BG); drv(120, 10, 12'h00F);
        // change coincident with frame start is captured
        g[0][0] = 4'd1;
        drv(0, 0, BG); drv(120, 10, 12'h0F0);

        // blink: frame counter now 3; code 8 hidden while count is 16..31
        for (int f = 4; f <= 40; f++) begin
            drv(0, 0, BG);
            drv(250, 70, (((f % 32) / 16) == 1) ? BG : 12'h880);
            drv(120, 10, 12'h0F0);
        end

        // one-cycle reset mid-line
        drvn(118, 10); drvn(119, 10);
        rst_n = 1'b0;
        drvn(120, 10);
        rst_n = 1'b1;
        for (int h = 121; h <= 130; h++) drv(h, 10, BG);
        drv(0, 0, BG); drv(120, 10, 12'h0F0); drv(250, 70, 12'h880);

        repeat (10) drvn(5, 5);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grid_sprite_renderer.md
# grid_sprite_renderer

Pipelined, parametrised renderer for the kitchen object grid. It walks the raster, maps each pixel to a grid tile, and fetches the tile's sprite texel from one shared sprite ROM. It then emits a 12-bit colour with syncs delayed to match. It adds three things to the fixed 8x13, 32-pixel single-cycle drawer:

- per-frame grid snapshot (no mid-frame tearing)
- colour-key transparency
- frame-counted blinking for selected object codes

It sits between the game-state grid and the final pixel mixer.

## Interface
Parameters:
- GRID_ROWS, 8, grid rows (indexed by vcount)
- GRID_COLS, 13, grid columns (indexed by hcount)
- TILE_LOG2, 5, tile edge = 2^TILE_LOG2 pixels, square
- OBJ_BITS, 4, bits per grid cell object code
- X0, 112, left pixel of grid; Y0, 0, top pixel of grid
- ROM_LATENCY, 2, sprite ROM read latency in clocks (1..3)
- ROM_AW, 14, sprite ROM address width, must be >= OBJ_BITS+2*TILE_LOG2
- KEY_COLOR, 12'hF0F, texel value treated as transparent
- BG_COLOR, 12'hFFF, background colour
- BLINK_MASK, 16'h0300, bit n set -> object code n blinks
- BLINK_LOG2, 4, blink half-period = 2^BLINK_LOG2 frames

Ports:
- pixel_clk_in  in  1  pixel clock, sole clock
- rst_in  in  1  synchronous, active-low reset
- object_grid  in  GRID_ROWS*GRID_COLS*OBJ_BITS  cell codes, cell (r,c) at bits [(r*GRID_COLS+c)*OBJ_BITS +: OBJ_BITS]
- hcount  in  11  raster x
- vcount  in  10  raster y
- hsync_in, vsync_in, blank_in  in  1 each  raster controls, same cycle as hcount/vcount
- rom_addr  out  ROM_AW  registered sprite ROM address
- rom_data  in  12  texel, valid ROM_LATENCY clocks after rom_addr
- pixel_out  out  12  colour {r,g,b}
- hsync_out, vsync_out, blank_out  out  1 each  controls delayed by LAT

## Operation
- LAT = 3 + ROM_LATENCY (default 5). Every output corresponds to inputs sampled LAT edges earlier.
- S0 (registered):
  - in_grid = X0 <= hcount < X0+GRID_COLS*2^TILE_LOG2 and Y0 <= vcount < Y0+GRID_ROWS*2^TILE_LOG2
  - col = (hcount-X0)>>TILE_LOG2, row = (vcount-Y0)>>TILE_LOG2
  - px/py = low TILE_LOG2 bits of the offsets
  - All subtractions are done at 12 bits. No wrap: out-of-range pixels have in_grid=0.
- S1: code = snapshot[row][col]. If in_grid=0, code is forced to 0.
- S2: rom_addr = {code, py, px}, zero-extended to ROM_AW. Sprite for code k occupies block k.
- Output stage:
  - blank delayed = 1 -> pixel_out = 12'h000
  - code 0 -> BG_COLOR
  - blink-suppressed -> BG_COLOR
  - rom_data == KEY_COLOR -> BG_COLOR
  - otherwise rom_data
- Snapshot: on the edge where S0 samples hcount==0 && vcount==0, snapshot <= object_grid and frame_cnt <= frame_cnt+1. Grid changes at any other time have no effect until the next frame start.
- Blink: phase = frame_cnt[BLINK_LOG2]. A code with BLINK_MASK[code]=1 is suppressed while phase=1. Phase is evaluated from the frame_cnt value alongside the S1 lookup, so one frame never mixes phases.
- Code and blink/transparency decisions are pipelined with the address, so they align with rom_data.
- frame_cnt is BLINK_LOG2+1 bits and wraps freely.

## Timing
- Reset (rst_in=0 at an edge):
  - pixel_out=0, syncs/blank out=0, rom_addr=0
  - snapshot all 0 (empty), frame_cnt=0, all pipeline valid/in_grid flags 0
- Reset mid-frame: outputs are 0 on the next edge. After release, the first LAT outputs are 0/background. The grid is empty until the next frame start.
- Throughput: one pixel per clock, no stalls, no backpressure.
- Frame-start pixel (0,0) uses the new snapshot.
- A simultaneous grid change and frame start captures the value present at that edge.
- Tile boundary: hcount = X0+n*2^TILE_LOG2 is the first pixel of column n. The last grid pixel is X0+GRID_COLS*2^TILE_LOG2-1.

## Test plan
- Reset, then a raster with cell (0,0)=1 and ROM block 1 all 12'h0F0:
  - pixel_out=12'h0F0 for hcount 112..143, vcount 0..31, exactly 5 clocks after sampling
  - BG_COLOR at hcount 111 and 144
- Change cell (0,0) from 1 to 3 at vcount=100 -> rest of frame still shows code 1; next frame shows code 3.
- Texel 12'hF0F at offset (5,7) of code 1 -> pixel at (117,7) = 12'hFFF; neighbours show ROM value.
- Code 8 in cell (2,4), BLINK_MASK bit 8 set:
  - visible frames 0..15 after reset wrap
  - BG in frames 16..31
  - visible again from frame 32
- Assert rst_in=0 for 1 cycle mid-line -> all outputs 0 next edge; grid empty until next (0,0); syncs realigned with LAT=5.
- ROM_LATENCY=1 build -> LAT=4. The hsync_out edge lags hsync_in by exactly 4 clocks.
